// File: rtl/bfm_ahbl_pkg.sv
// Shared AHB-Lite encodings, responder FSM state type and byte-lane helpers.
package bfm_ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Little-endian lane strobes for a legal transfer.
    function automatic logic [3:0] byte_en(input logic [2:0] hsize, input logic [1:0] addr);
        case (hsize)
            HSIZE_BYTE: return 4'b0001 << addr;
            HSIZE_HALF: return addr[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] hsize, input logic [1:0] addr);
        return (hsize > HSIZE_WORD) ||
               ((hsize == HSIZE_HALF) && addr[0]) ||
               ((hsize == HSIZE_WORD) && (addr != 2'b00));
    endfunction

endpackage

// File: rtl/bfm_ahbl_slave_ram.sv
// Single-port 32-bit word RAM with per-byte write strobes.
// Latency: write on the clock edge, read combinational.
// Backpressure: none, always ready.
module bfm_ahbl_slave_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/bfm_ahbl_slave_mem.sv
// AHB-Lite responder backed by a local word memory, with transfer counters.
// Latency: OKAY data phase is WAIT_STATES+1 cycles, ERROR data phase is 2 cycles.
// Backpressure: HREADYOUT low during wait states and the first ERROR cycle.
module bfm_ahbl_slave_mem
    import bfm_ahbl_pkg::*;
#(
    parameter int AWIDTH      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETN,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADYIN,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [15:0] WR_COUNT,
    output logic [15:0] RD_COUNT,
    output logic [15:0] ERR_COUNT
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t            state;
    logic [AWIDTH-1:0] addr_q;
    logic              write_q;
    logic [2:0]        size_q;
    logic [3:0]        wait_cnt;
    logic              accept;
    logic              ram_we;
    logic [31:0]       ram_rdata;
    logic              unused_ok;

    assign accept    = HSEL & HREADYIN & HTRANS[1];
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:AWIDTH]};

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            size_q    <= HSIZE_BYTE;
            wait_cnt  <= 4'd0;
            WR_COUNT  <= 16'd0;
            RD_COUNT  <= 16'd0;
            ERR_COUNT <= 16'd0;
        end else begin
            if (state == ST_DATA) begin
                if (write_q) WR_COUNT <= WR_COUNT + 16'd1;
                else         RD_COUNT <= RD_COUNT + 16'd1;
            end
            if (state == ST_ERR1) ERR_COUNT <= ERR_COUNT + 16'd1;

            case (state)
                // Address phases are only taken while the bus is ready.
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        addr_q  <= HADDR[AWIDTH-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE;
                        if (is_illegal(HSIZE, HADDR[1:0])) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                        end else if (WAIT_STATES == 0) begin
                            state     <= ST_DATA;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                        end else begin
                            state     <= ST_WAIT;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                            wait_cnt  <= WAIT_LOAD;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= ST_DATA;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                end
            endcase
        end
    end

    // The write lands on the edge leaving DATA, unless reset wins that edge.
    assign ram_we = HRESETN && (state == ST_DATA) && write_q;

    bfm_ahbl_slave_ram #(
        .AW(AWIDTH - 2)
    ) u_ram (
        .clk   (HCLK),
        .we    (ram_we),
        .be    (byte_en(size_q, addr_q[1:0])),
        .addr  (addr_q[AWIDTH-1:2]),
        .wdata (HWDATA),
        .rdata (ram_rdata)
    );

    assign HRDATA = (state == ST_DATA) ? ram_rdata : 32'd0;

endmodule

// File: doc/bfm_ahbl_slave_mem.md
# bfm_ahbl_slave_mem

AHB-Lite responder with a local word memory. It is the slave-side counterpart of the AHB-Lite master bus-functional model in the CoreUARTapb verification environment, and lets master BFM scripts run write/read/compare sequences without a real peripheral. Each instance is attached to one HSEL line of the master BFM. It has configurable wait states, a two-cycle ERROR response for illegal transfers, and transfer counters for bench checking.

## Interface
- AWIDTH, 10, byte-address width of the memory; depth is 2^(AWIDTH-2) 32-bit words.
- WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase; range 0..15.
- HCLK  in  1  clock; all logic on rising edge.
- HRESETN  in  1  reset, synchronous, active-low.
- HSEL  in  1  slave select.
- HADDR  in  32  address; only HADDR[AWIDTH-1:0] is used.
- HTRANS  in  2  transfer type: IDLE, BUSY, NONSEQ or SEQ.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HBURST, HPROT, HMASTLOCK  in  3/4/1  accepted and ignored.
- HWDATA  in  32  write data.
- HREADYIN  in  1  bus HREADY.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  1 = ERROR.
- WR_COUNT, RD_COUNT, ERR_COUNT  out  16 each  completed OKAY writes, completed OKAY reads, and ERROR responses.

## Operation
- Accept condition: HSEL & HREADYIN & HTRANS[1].
  - On accept, latch address, HWRITE and HSIZE into the data-phase registers.
  - IDLE and BUSY transfers are never accepted; they get a zero-wait OKAY.
- A transfer is illegal when either holds:
  - HSIZE > 2.
  - Misaligned: halfword with HADDR[0]=1, or word with HADDR[1:0]≠0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - Any state with HREADYOUT=1 (IDLE, DATA, ERR2), on accept: illegal → ERR1; legal with WAIT_STATES=0 → DATA; legal with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES-1.
  - Same states with no accept → IDLE.
  - WAIT: counter decrements each cycle; at 0 → DATA.
  - ERR1 → ERR2 unconditionally.
- Output decode:
  - IDLE/DATA: HREADYOUT=1, HRESP=0.
  - WAIT: HREADYOUT=0, HRESP=0.
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
- Write commit happens at the clock edge that ends DATA.
  - Little-endian byte lanes; byte enables come from the latched HSIZE and HADDR[1:0].
  - Byte: lane = addr[1:0]. Halfword: lanes {addr[1],0} and {addr[1],1}. Word: all four lanes.
- Read data:
  - HRDATA = full word mem[addr_q[AWIDTH-1:2]], driven combinationally while in DATA; 0 in every other state.
  - A read directly after a write to the same word returns the new data, because the write commits before the read's DATA state.
- Counters:
  - WR_COUNT / RD_COUNT increment on the DATA-exit edge; ERR_COUNT increments on ERR1.
  - All wrap at 16 bits without saturation.
- Address wrap: offsets above the memory depth alias via truncation to AWIDTH bits; this is not an error.
- Memory contents are not reset; a read of an unwritten word returns X in simulation.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, all counters 0, WAIT counter 0.
- Reset asserted mid-transfer: FSM goes to IDLE on that edge, and a pending write is not committed.
- Latency:
  - OKAY data phase lasts WAIT_STATES+1 cycles.
  - ERROR data phase lasts exactly 2 cycles.
- Pipelining: a new address phase is accepted in the same cycle as the current DATA or ERR2, which gives back-to-back zero-wait throughput of one transfer per cycle.
- During ERR1 the master may change HTRANS to IDLE. HREADYIN is low in that cycle, so nothing is accepted.

## Structure
- Shared package bfm_ahbl_pkg holds:
  - HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
  - HSIZE constants.
  - The FSM state typedef.
  - A byte-enable function (hsize, addr[1:0]) → 4-bit strobe.
- One natural sub-module, bfm_ahbl_slave_ram: single-port word RAM with 4-bit byte write strobes and asynchronous read.

## Test plan
- WAIT_STATES=0: NONSEQ word write 0xDEADBEEF to 0x010, then read 0x010 in the next cycle → HRDATA=0xDEADBEEF in the read's data phase; HREADYOUT held at 1 throughout; WR_COUNT=1, RD_COUNT=1.
- Byte writes 0x11/0x22/0x33/0x44 to 0x020..0x023, then word read 0x020 → 0x44332211; halfword write 0xAABB to 0x022, then read → 0xAABB2211.
- WAIT_STATES=3: single read → HREADYOUT low for exactly 3 cycles, then high with data; a second NONSEQ presented during those wait cycles is not accepted until HREADYIN=1.
- Word write to 0x002 (misaligned) → ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (1,1); memory unchanged; ERR_COUNT=1. HSIZE=3 gives the same result.
- HTRANS=BUSY or IDLE with HSEL=1, and NONSEQ with HSEL=0 → no state change, OKAY response, counters unchanged.
- Assert HRESETN=0 during the WAIT of a write with WAIT_STATES=2 → next cycle HREADYOUT=1, HRESP=0, counters 0; a subsequent read of that address returns the previous contents.
